// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - default 640x480 VGA timing constants and colour types
package vga_pkg;

  localparam int CNT_W = 11;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;

  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic visible;
  } ctrl_t;

  // Bit replication so full-scale 3/2-bit codes map to 8'hFF and zero to 8'h00.
  function automatic rgb888_t expand_rgb(input rgb332_t c);
    rgb888_t e;
    e.r = {c.r, c.r, c.r[2:1]};
    e.g = {c.g, c.g, c.g[2:1]};
    e.b = {c.b, c.b, c.b, c.b};
    return e;
  endfunction

endpackage

// File: rtl/vga_timing_gen_pipe_delay.sv
// rtl/vga_timing_gen_pipe_delay.sv - fixed-depth register delay line with reset value
module pipe_delay #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stages [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stages[i] <= RST_VAL;
    end else begin
      stages[0] <= d;
      for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign q = stages[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA counters, sync/blank generation and colour output alignment
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int RGB_LATENCY = 1,
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int H_FP        = DEF_H_FP,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BP        = DEF_H_BP,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int V_FP        = DEF_V_FP,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BP        = DEF_V_BP
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [7:0]  RGB_in,
  output logic [10:0] pixelX,
  output logic [10:0] pixelY,
  output logic        startOfFrame,
  output logic        hsyncN,
  output logic        vsyncN,
  output logic        blankN,
  output logic [7:0]  vgaR,
  output logic [7:0]  vgaG,
  output logic [7:0]  vgaB
);

  localparam int H_PERIOD = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_PERIOD = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_PERIOD - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_PERIOD - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             sof;
  ctrl_t            raw;
  ctrl_t            aligned;
  rgb332_t          rgb_q;
  rgb888_t          rgb_exp;

  // The pulse is decoded from the pre-wrap count, so it lands in the (0,0) cycle
  // and never fires for the frame that starts out of reset.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      h_cnt <= '0;
      v_cnt <= '0;
      sof   <= 1'b0;
    end else begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
      end else begin
        h_cnt <= h_cnt + CNT_W'(1);
      end
      sof <= (h_cnt == H_LAST) && (v_cnt == V_LAST);
    end
  end

  always_comb begin
    raw         = '0;
    raw.hsync   = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
    raw.vsync   = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);
    raw.visible = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  end

  // Controls wait for the background drawer plus the RGB_in capture register.
  pipe_delay #(
    .WIDTH   ($bits(ctrl_t)),
    .DEPTH   (RGB_LATENCY + 1),
    .RST_VAL ('0)
  ) u_ctrl_delay (
    .clk   (clk),
    .rst_n (resetN),
    .d     (raw),
    .q     (aligned)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rgb_q <= '0;
    end else begin
      rgb_q <= rgb332_t'(RGB_in);
    end
  end

  assign rgb_exp      = expand_rgb(rgb_q);
  assign pixelX       = h_cnt;
  assign pixelY       = v_cnt;
  assign startOfFrame = sof;
  assign hsyncN       = ~aligned.hsync;
  assign vsyncN       = ~aligned.vsync;
  assign blankN       = aligned.visible;
  assign vgaR         = aligned.visible ? rgb_exp.r : 8'h00;
  assign vgaG         = aligned.visible ? rgb_exp.g : 8'h00;
  assign vgaB         = aligned.visible ? rgb_exp.b : 8'h00;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

  localparam int S_HA = 40;
  localparam int S_HF = 4;
  localparam int S_HS = 8;
  localparam int S_HB = 8;
  localparam int S_VA = 30;
  localparam int S_VF = 2;
  localparam int S_VS = 2;
  localparam int S_VB = 3;
  localparam int S_HT = S_HA + S_HF + S_HS + S_HB;
  localparam int S_VT = S_VA + S_VF + S_VS + S_VB;
  localparam int S_FRAME = S_HT * S_VT;
  localparam int NV = 13;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_def, rst_small;
  logic [7:0] rgb_def, rgb_lat, rgb_small;

  logic [10:0] px_d, py_d, px_l, py_l, px_s, py_s;
  logic sof_d, hs_d, vs_d, bl_d;
  logic sof_l, hs_l, vs_l, bl_l;
  logic sof_s, hs_s, vs_s, bl_s;
  logic [7:0] r_d, g_d, b_d, r_l, g_l, b_l, r_s, g_s, b_s;

  vga_timing_gen u_def (
    .clk(clk), .resetN(rst_def), .RGB_in(rgb_def),
    .pixelX(px_d), .pixelY(py_d), .startOfFrame(sof_d),
    .hsyncN(hs_d), .vsyncN(vs_d), .blankN(bl_d),
    .vgaR(r_d), .vgaG(g_d), .vgaB(b_d)
  );

  vga_timing_gen #(.RGB_LATENCY(3)) u_lat3 (
    .clk(clk), .resetN(rst_def), .RGB_in(rgb_lat),
    .pixelX(px_l), .pixelY(py_l), .startOfFrame(sof_l),
    .hsyncN(hs_l), .vsyncN(vs_l), .blankN(bl_l),
    .vgaR(r_l), .vgaG(g_l), .vgaB(b_l)
  );

  vga_timing_gen #(
    .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB)
  ) u_small (
    .clk(clk), .resetN(rst_small), .RGB_in(rgb_small),
    .pixelX(px_s), .pixelY(py_s), .startOfFrame(sof_s),
    .hsyncN(hs_s), .vsyncN(vs_s), .blankN(bl_s),
    .vgaR(r_s), .vgaG(g_s), .vgaB(b_s)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input bit ok, input string info);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: %s", name, info);
    end
  endtask

  task automatic check_reset(input string name, input logic [10:0] x, input logic [10:0] y,
                             input logic sof, input logic hs, input logic vs, input logic bl,
                             input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    check(name, x === 11'd0 && y === 11'd0 && sof === 1'b0 && hs === 1'b1 && vs === 1'b1 &&
                bl === 1'b0 && r === 8'h00 && g === 8'h00 && b === 8'h00,
          $sformatf("got x=%0d y=%0d sof=%b hs=%b vs=%b bl=%b rgb=%h_%h_%h, want 0 0 0 1 1 0 00_00_00",
                    x, y, sof, hs, vs, bl, r, g, b));
  endtask

  typedef struct {
    int         h;
    logic       bl;
    logic       hs;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } vec_t;

  vec_t tbl[NV];
  bit   hit[NV];

  // Scoreboard of the scaled-down instance from reset release: counter, control,
  // colour and frame-pulse models plus per-frame sync statistics.
  task automatic run_small(input int frames, input string tag);
    int px, py, x1, y1, x2, y2, ex, ey;
    int sof_first, sof_second, cnt_err, ctrl_err, vga_err, sof_err;
    int hs_falls, hs_low, vs_low;
    logic exp_bl, exp_hs, exp_vs, exp_sof, hs_prev;
    logic [23:0] exp_rgb;
    bit sof_drop;
    sof_first = -1; sof_second = -1;
    cnt_err = 0; ctrl_err = 0; vga_err = 0; sof_err = 0;
    hs_falls = 0; hs_low = 0; vs_low = 0;
    x1 = 0; y1 = 0; x2 = 0; y2 = 0;
    hs_prev = 1'b1; sof_drop = 1'b0;
    rst_small = 1'b1;
    for (int k = 0; k < frames * S_FRAME + 5; k++) begin
      if (k > 0) @(negedge clk);
      px = int'(px_s);
      py = int'(py_s);
      if (k == 0) begin
        ex = 0; ey = 0;
      end else begin
        ex = (x1 == S_HT - 1) ? 0 : x1 + 1;
        ey = (x1 != S_HT - 1) ? y1 : ((y1 == S_VT - 1) ? 0 : y1 + 1);
      end
      if (px != ex || py != ey) cnt_err++;
      if (k >= 2) begin
        exp_bl = (x2 < S_HA) && (y2 < S_VA);
        exp_hs = !((x2 >= S_HA + S_HF) && (x2 < S_HA + S_HF + S_HS));
        exp_vs = !((y2 >= S_VA + S_VF) && (y2 < S_VA + S_VF + S_VS));
      end else begin
        exp_bl = 1'b0; exp_hs = 1'b1; exp_vs = 1'b1;
      end
      if (bl_s !== exp_bl || hs_s !== exp_hs || vs_s !== exp_vs) ctrl_err++;
      exp_rgb = exp_bl ? 24'hFFFFFF : 24'h000000;
      if ({r_s, g_s, b_s} !== exp_rgb) vga_err++;
      exp_sof = (k > 0) && (x1 == S_HT - 1) && (y1 == S_VT - 1);
      if (sof_s !== exp_sof) sof_err++;
      if (sof_s === 1'b1) begin
        if (sof_first < 0) sof_first = k;
        else if (sof_second < 0) sof_second = k;
      end
      if (sof_first >= 0 && sof_second < 0) begin
        if (hs_s === 1'b0) hs_low++;
        if (hs_s === 1'b0 && hs_prev === 1'b1) hs_falls++;
        if (vs_s === 1'b0) vs_low++;
      end
      hs_prev = hs_s;
      if (k > 0 && x1 == S_HT - 1 && y1 == S_VA - 1)
        check({tag, " wrap_to_blank_line"}, px == 0 && py == S_VA,
              $sformatf("got (%0d,%0d) want (0,%0d)", px, py, S_VA));
      if (k > 0 && x1 == S_HT - 1 && y1 == S_VT - 1) begin
        check({tag, " wrap_to_frame_start"}, px == 0 && py == 0 && sof_s === 1'b1,
              $sformatf("got (%0d,%0d) sof=%b want (0,0) sof=1", px, py, sof_s));
        sof_drop = 1'b1;
      end else if (sof_drop) begin
        check({tag, " sof_one_clock"}, sof_s === 1'b0, $sformatf("got sof=%b want 0", sof_s));
        sof_drop = 1'b0;
      end
      if (k >= 2 && ((x2 == S_HA && y2 == 0) || (x2 == 0 && y2 == S_VA)))
        check($sformatf("%s blank_at_%0d_%0d", tag, x2, y2), bl_s === 1'b0 && {r_s, g_s, b_s} === 24'h0,
              $sformatf("got bl=%b rgb=%h_%h_%h want bl=0 rgb=00_00_00", bl_s, r_s, g_s, b_s));
      if (k >= 2 && x2 == S_HA - 1 && y2 == S_VA - 1)
        check({tag, " last_visible"}, bl_s === 1'b1 && {r_s, g_s, b_s} === 24'hFFFFFF,
              $sformatf("got bl=%b rgb=%h_%h_%h want bl=1 rgb=ff_ff_ff", bl_s, r_s, g_s, b_s));
      x2 = x1; y2 = y1; x1 = px; y1 = py;
    end
    check({tag, " counter_model"}, cnt_err == 0, $sformatf("got %0d errors want 0", cnt_err));
    check({tag, " sync_blank_model"}, ctrl_err == 0, $sformatf("got %0d errors want 0", ctrl_err));
    check({tag, " colour_model"}, vga_err == 0, $sformatf("got %0d errors want 0", vga_err));
    check({tag, " sof_model"}, sof_err == 0, $sformatf("got %0d errors want 0", sof_err));
    check({tag, " first_sof"}, sof_first == S_FRAME, $sformatf("got %0d want %0d", sof_first, S_FRAME));
    if (frames >= 2) begin
      check({tag, " sof_period"}, sof_second - sof_first == S_FRAME,
            $sformatf("got %0d want %0d", sof_second - sof_first, S_FRAME));
      check({tag, " hsync_pulses"}, hs_falls == S_VT, $sformatf("got %0d want %0d", hs_falls, S_VT));
      check({tag, " hsync_low_clocks"}, hs_low == S_VT * S_HS,
            $sformatf("got %0d want %0d", hs_low, S_VT * S_HS));
      check({tag, " vsync_low_clocks"}, vs_low == S_VS * S_HT,
            $sformatf("got %0d want %0d", vs_low, S_VS * S_HT));
    end
  endtask

  initial begin
    int hx1, hy1, hx2, hy2, k656;
    bit found;

    tbl[0]  = '{0,   1'b1, 1'b1, 8'h00, 8'h00, 8'h00};
    tbl[1]  = '{5,   1'b1, 1'b1, 8'h00, 8'h24, 8'h55};
    tbl[2]  = '{147, 1'b1, 1'b1, 8'h92, 8'h92, 8'hFF};
    tbl[3]  = '{167, 1'b1, 1'b1, 8'hB6, 8'h24, 8'hFF};
    tbl[4]  = '{255, 1'b1, 1'b1, 8'hFF, 8'hFF, 8'hFF};
    tbl[5]  = '{639, 1'b1, 1'b1, 8'h6D, 8'hFF, 8'hFF};
    tbl[6]  = '{640, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00};
    tbl[7]  = '{655, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00};
    tbl[8]  = '{656, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
    tbl[9]  = '{751, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
    tbl[10] = '{752, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00};
    tbl[11] = '{799, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00};
    tbl[12] = '{128, 1'b1, 1'b1, 8'h92, 8'h00, 8'h00};
    for (int i = 0; i < NV; i++) hit[i] = 1'b0;

    rst_def = 1'b0; rst_small = 1'b0;
    rgb_def = 8'h00; rgb_lat = 8'h00; rgb_small = 8'hFF;
    repeat (3) @(negedge clk);
    check_reset("reset_default", px_d, py_d, sof_d, hs_d, vs_d, bl_d, r_d, g_d, b_d);
    check_reset("reset_latency3", px_l, py_l, sof_l, hs_l, vs_l, bl_l, r_l, g_l, b_l);
    check_reset("reset_small", px_s, py_s, sof_s, hs_s, vs_s, bl_s, r_s, g_s, b_s);

    // Line 0 of the default timing, with a one-clock drawer returning pixelX[7:0].
    hx1 = 0; hy1 = 0; hx2 = 0; hy2 = 0; k656 = -100;
    for (int k = 0; k < 805; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 1)
        check("blank_before_first_pixel", bl_d === 1'b0, $sformatf("got bl=%b want 0", bl_d));
      if (k >= 2 && hy2 == 0) begin
        for (int i = 0; i < NV; i++) begin
          if (tbl[i].h == hx2) begin
            hit[i] = 1'b1;
            check($sformatf("pixel_%0d", hx2),
                  bl_d === tbl[i].bl && hs_d === tbl[i].hs && vs_d === 1'b1 &&
                  r_d === tbl[i].r && g_d === tbl[i].g && b_d === tbl[i].b,
                  $sformatf("got bl=%b hs=%b vs=%b rgb=%h_%h_%h want bl=%b hs=%b vs=1 rgb=%h_%h_%h",
                            bl_d, hs_d, vs_d, r_d, g_d, b_d,
                            tbl[i].bl, tbl[i].hs, tbl[i].r, tbl[i].g, tbl[i].b));
          end
        end
      end
      if (px_l == 11'd656 && py_l == 11'd0) k656 = k;
      if (k == k656 + 3)
        check("lat3_hsync_before", hs_l === 1'b1, $sformatf("got hs=%b want 1", hs_l));
      if (k == k656 + 4)
        check("lat3_hsync_fall", hs_l === 1'b0, $sformatf("got hs=%b want 0", hs_l));
      rgb_def = (k == 0) ? 8'h00 : 8'(hx1);
      hx2 = hx1; hy2 = hy1;
      hx1 = int'(px_d); hy1 = int'(py_d);
      if (k == 0) rst_def = 1'b1;
    end
    for (int i = 0; i < NV; i++)
      check($sformatf("vector_%0d_reached", tbl[i].h), hit[i], "got not reached want reached");
    check("lat3_656_seen", k656 >= 0, $sformatf("got index %0d want >= 0", k656));

    run_small(2, "free_run");

    found = 1'b0;
    for (int k = 0; k < S_FRAME + 10; k++) begin
      @(negedge clk);
      if (px_s == 11'd30 && py_s == 11'd20) begin
        found = 1'b1;
        break;
      end
    end
    check("reach_mid_frame", found, "got not reached want (30,20)");
    check("pre_reset_visible", bl_s === 1'b1 && r_s === 8'hFF,
          $sformatf("got bl=%b r=%h want bl=1 r=ff", bl_s, r_s));
    #2 rst_small = 1'b0;
    #1 check_reset("async_reset_now", px_s, py_s, sof_s, hs_s, vs_s, bl_s, r_s, g_s, b_s);
    @(negedge clk);
    check_reset("reset_held", px_s, py_s, sof_s, hs_s, vs_s, bl_s, r_s, g_s, b_s);
    run_small(1, "after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
